// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative multiplier; also used by the control
// decoder that drives Start, Signed and HighHalf from the opcode.
package mul_pkg;

  localparam int MUL_W     = 16;
  localparam int MUL_CNT_W = $clog2(MUL_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    WB   = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: operand magnitude conversion, 2n-bit accumulator,
// multiplicand/multiplier shifters and the final conditional negate.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int n = MUL_W
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic           load,
  input  logic           step,
  input  logic           sign_mode,
  input  logic           negate,
  input  logic [n-1:0]   op_a,
  input  logic [n-1:0]   op_b,
  output logic [2*n-1:0] product
);

  logic [2*n-1:0] mcand;
  logic [n-1:0]   mplier;
  logic [2*n-1:0] acc;
  logic [n-1:0]   mag_a;
  logic [n-1:0]   mag_b;

  // -2^(n-1) negates to itself, which read as unsigned is the correct magnitude.
  assign mag_a = (sign_mode && op_a[n-1]) ? -op_a : op_a;
  assign mag_b = (sign_mode && op_b[n-1]) ? -op_b : op_b;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{n{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product = negate ? -acc : acc;

endmodule

// File: rtl/mul_unit.sv
// Iterative 16x16 multiplier sitting between the register block read ports and
// its write port: FSM, bit counter, capture registers and writeback handshake.
module mul_unit
  import mul_pkg::*;
#(
  parameter int n         = MUL_W,
  parameter int addr_size = 3
) (
  input  logic                 Clock,
  input  logic                 nReset,
  input  logic                 Start,
  input  logic                 Signed,
  input  logic                 HighHalf,
  input  logic [n-1:0]         OpA,
  input  logic [n-1:0]         OpB,
  input  logic [addr_size-1:0] RdAddr,
  output logic                 Busy,
  output logic                 WbReq,
  input  logic                 WbGrant,
  output logic [n-1:0]         WData,
  output logic [addr_size-1:0] Rw,
  output logic                 We,
  output logic                 Done,
  output mul_state_t           dbg_state
);

  localparam int              cnt_w    = $clog2(n + 1);
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'(n);

  mul_state_t       state;
  logic [cnt_w-1:0] count;
  logic             neg_q;
  logic             high_q;
  logic             load;
  logic             step;
  logic [2*n-1:0]   product;

  // Handshake: WbReq rises on WB entry and stays high, with WData/Rw frozen,
  // until an edge where WbGrant=1; that edge is the write (We) and drops WbReq.
  assign Busy      = (state != IDLE);
  assign WbReq     = (state == WB);
  assign We        = WbReq & WbGrant;
  assign dbg_state = state;

  assign load = (state == IDLE) && Start;
  assign step = (state == MUL) && (count != last_cnt);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      count  <= '0;
      neg_q  <= 1'b0;
      high_q <= 1'b0;
      WData  <= '0;
      Rw     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= We;
      case (state)
        IDLE: begin
          if (Start) begin
            state  <= MUL;
            count  <= '0;
            neg_q  <= Signed & (OpA[n-1] ^ OpB[n-1]);
            high_q <= HighHalf;
            Rw     <= RdAddr;
          end
        end
        MUL: begin
          if (count == last_cnt) begin
            state <= WB;
            WData <= high_q ? product[2*n-1:n] : product[n-1:0];
          end else begin
            count <= count + 1'b1;
          end
        end
        WB: begin
          if (WbGrant) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mul_datapath #(.n(n)) u_datapath (
    .Clock     (Clock),
    .nReset    (nReset),
    .load      (load),
    .step      (step),
    .sign_mode (Signed),
    .negate    (neg_q),
    .op_a      (OpA),
    .op_b      (OpB),
    .product   (product)
  );

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus randomized
// operations checked against an arithmetic reference model.
module tb_mul_unit;
  import mul_pkg::*;

  logic        Clock;
  logic        nReset;
  logic        Start;
  logic        Signed;
  logic        HighHalf;
  logic [15:0] OpA;
  logic [15:0] OpB;
  logic [2:0]  RdAddr;
  logic        Busy;
  logic        WbReq;
  logic        WbGrant;
  logic [15:0] WData;
  logic [2:0]  Rw;
  logic        We;
  logic        Done;
  mul_state_t  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mul_unit #(.n(16), .addr_size(3)) dut (
    .Clock     (Clock),
    .nReset    (nReset),
    .Start     (Start),
    .Signed    (Signed),
    .HighHalf  (HighHalf),
    .OpA       (OpA),
    .OpB       (OpB),
    .RdAddr    (RdAddr),
    .Busy      (Busy),
    .WbReq     (WbReq),
    .WbGrant   (WbGrant),
    .WData     (WData),
    .Rw        (Rw),
    .We        (We),
    .Done      (Done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // reference model: exact product by plain integer arithmetic
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit s, input bit h);
    longint      pa;
    longint      pb;
    logic [63:0] p;
    pa = s ? longint'($signed(a)) : longint'({48'd0, a});
    pb = s ? longint'($signed(b)) : longint'({48'd0, b});
    p  = pa * pb;
    return h ? p[31:16] : p[15:0];
  endfunction

  // driver: issue one op, watch it through writeback, report observations
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit s, input bit h,
                        input logic [2:0] addr, input int stall, input bit poke,
                        output int lat, output logic [15:0] data, output logic [2:0] rw,
                        output int we_cnt, output bit stable, output bit done_ok,
                        output bit busy_ok);
    @(negedge Clock);
    Start = 1'b1; Signed = s; HighHalf = h; OpA = a; OpB = b; RdAddr = addr;
    WbGrant = (stall == 0);
    @(posedge Clock); #1;
    Start = 1'b0;
    OpA = 16'($urandom); OpB = 16'($urandom); RdAddr = 3'($urandom);
    lat = -1; we_cnt = 0; stable = 1'b1; done_ok = 1'b0; busy_ok = 1'b1;
    data = 'x; rw = 'x;
    for (int j = 1; j <= 40; j++) begin
      @(posedge Clock); #1;
      Start = poke && (j == 5);
      if (We) we_cnt++;
      if (WbReq) begin lat = j; break; end
      if (Busy !== 1'b1) busy_ok = 1'b0;
    end
    Start = 1'b0;
    if (lat < 0) return;
    data = WData; rw = Rw;
    if (stall > 0) begin
      for (int c = 0; c < stall; c++) begin
        @(posedge Clock); #1;
        if (We) we_cnt++;
        if (WbReq !== 1'b1 || WData !== data || Rw !== rw) stable = 1'b0;
      end
      WbGrant = 1'b1; #1;
      if (We) we_cnt++;
    end
    @(posedge Clock); #1;
    done_ok = (Done === 1'b1) && (Busy === 1'b0) && (We === 1'b0);
    @(posedge Clock); #1;
    if (Done !== 1'b0) done_ok = 1'b0;
    if (We) we_cnt++;
  endtask

  task automatic test_reset();
    nReset = 1'b0; Start = 1'b0; Signed = 1'b0; HighHalf = 1'b0;
    OpA = '0; OpB = '0; RdAddr = '0; WbGrant = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    n_checks++; if ({Busy, WbReq, We, Done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", {Busy, WbReq, We, Done}); end
    n_checks++; if (WData !== 16'h0 || Rw !== 3'd0) begin n_fail++; $display("FAIL reset_data got WData=%h Rw=%0d exp 0/0", WData, Rw); end
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    nReset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_unsigned_basic();
    int lat, we_cnt; logic [15:0] d; logic [2:0] rw; bit st, dn, bz;
    run_op(16'd3, 16'd5, 1'b0, 1'b0, 3'd2, 0, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
    n_checks++; if (lat != 17) begin n_fail++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    n_checks++; if (d !== 16'h000F) begin n_fail++; $display("FAIL basic_data got=%h exp=000f", d); end
    n_checks++; if (rw !== 3'd2) begin n_fail++; $display("FAIL basic_rw got=%0d exp=2", rw); end
    n_checks++; if (!dn) begin n_fail++; $display("FAIL basic_done got=0 exp=1"); end
    n_checks++; if (we_cnt != 1) begin n_fail++; $display("FAIL basic_we_count got=%0d exp=1", we_cnt); end
  endtask

  task automatic test_unsigned_max();
    int lat, we_cnt; logic [15:0] d; logic [2:0] rw; bit st, dn, bz;
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 3'd1, 0, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
    n_checks++; if (d !== 16'hFFFE) begin n_fail++; $display("FAIL umax_high got=%h exp=fffe", d); end
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 3'd1, 0, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
    n_checks++; if (d !== 16'h0001) begin n_fail++; $display("FAIL umax_low got=%h exp=0001", d); end
  endtask

  task automatic test_signed();
    int lat, we_cnt; logic [15:0] d; logic [2:0] rw; bit st, dn, bz;
    logic [15:0] ta [4] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'h8000};
    logic [15:0] tb [4] = '{16'h0007, 16'h0007, 16'hFFFF, 16'hFFFF};
    bit          th [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] te [4] = '{16'hFFEB, 16'hFFFF, 16'h8000, 16'h0000};
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], 1'b1, th[i], 3'd4, 0, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
      n_checks++; if (d !== te[i]) begin n_fail++; $display("FAIL signed_%0d got=%h exp=%h", i, d, te[i]); end
    end
  endtask

  task automatic test_grant_stall();
    int lat, we_cnt; logic [15:0] d; logic [2:0] rw; bit st, dn, bz;
    run_op(16'h1234, 16'h00AB, 1'b0, 1'b0, 3'd6, 5, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
    n_checks++; if (!st) begin n_fail++; $display("FAIL stall_stable got=0 exp=1"); end
    n_checks++; if (we_cnt != 1) begin n_fail++; $display("FAIL stall_we_count got=%0d exp=1", we_cnt); end
    n_checks++; if (d !== ref_mul(16'h1234, 16'h00AB, 1'b0, 1'b0) || rw !== 3'd6) begin n_fail++; $display("FAIL stall_result got=%h/%0d exp=%h/6", d, rw, ref_mul(16'h1234, 16'h00AB, 1'b0, 1'b0)); end
    n_checks++; if (!dn) begin n_fail++; $display("FAIL stall_done got=0 exp=1"); end
  endtask

  task automatic test_start_ignored();
    int lat, we_cnt; logic [15:0] d; logic [2:0] rw; bit st, dn, bz;
    run_op(16'h0101, 16'h0033, 1'b0, 1'b0, 3'd3, 0, 1'b1, lat, d, rw, we_cnt, st, dn, bz);
    n_checks++; if (d !== 16'h3333 || rw !== 3'd3) begin n_fail++; $display("FAIL ignore_result got=%h/%0d exp=3333/3", d, rw); end
    n_checks++; if (!bz || lat != 17) begin n_fail++; $display("FAIL ignore_busy busy_ok=%0d lat=%0d exp 1/17", bz, lat); end
    n_checks++; if (we_cnt != 1) begin n_fail++; $display("FAIL ignore_we_count got=%0d exp=1", we_cnt); end
  endtask

  task automatic test_reset_abort();
    int lat, we_cnt, we_seen; logic [15:0] d; logic [2:0] rw; bit st, dn, bz;
    @(negedge Clock);
    Start = 1'b1; Signed = 1'b0; HighHalf = 1'b0; OpA = 16'h1234; OpB = 16'h0056; RdAddr = 3'd5;
    WbGrant = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    repeat (8) @(posedge Clock);
    #1;
    nReset = 1'b0; #1;
    n_checks++; if (Busy !== 1'b0 || WbReq !== 1'b0) begin n_fail++; $display("FAIL abort_async got Busy=%b WbReq=%b exp 0/0", Busy, WbReq); end
    we_seen = 0;
    for (int c = 0; c < 3; c++) begin @(posedge Clock); #1; if (We) we_seen++; end
    nReset = 1'b1;
    for (int c = 0; c < 25; c++) begin @(posedge Clock); #1; if (We || Busy) we_seen++; end
    n_checks++; if (we_seen != 0) begin n_fail++; $display("FAIL abort_no_write got=%0d exp=0", we_seen); end
    run_op(16'hFF00, 16'h0102, 1'b1, 1'b0, 3'd7, 0, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
    n_checks++; if (d !== ref_mul(16'hFF00, 16'h0102, 1'b1, 1'b0) || rw !== 3'd7) begin n_fail++; $display("FAIL abort_recover got=%h/%0d exp=%h/7", d, rw, ref_mul(16'hFF00, 16'h0102, 1'b1, 1'b0)); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2, d1;
    int lat;
    a1 = 16'($urandom); b1 = 16'($urandom); a2 = 16'($urandom); b2 = 16'($urandom);
    @(negedge Clock);
    Start = 1'b1; Signed = 1'b1; HighHalf = 1'b1; OpA = a1; OpB = b1; RdAddr = 3'd1; WbGrant = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin @(posedge Clock); #1; if (WbReq) begin lat = j; break; end end
    d1 = WData;
    n_checks++; if (lat != 17 || d1 !== ref_mul(a1, b1, 1'b1, 1'b1)) begin n_fail++; $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=17", d1, lat, ref_mul(a1, b1, 1'b1, 1'b1)); end
    @(posedge Clock); #1;
    // Done cycle: a new Start here must be accepted
    Start = 1'b1; Signed = 1'b0; HighHalf = 1'b0; OpA = a2; OpB = b2; RdAddr = 3'd2;
    @(posedge Clock); #1;
    Start = 1'b0;
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got Busy=%b exp=1", Busy); end
    lat = -1;
    for (int j = 1; j <= 40; j++) begin @(posedge Clock); #1; if (WbReq) begin lat = j; break; end end
    n_checks++; if (lat != 17 || WData !== ref_mul(a2, b2, 1'b0, 1'b0) || Rw !== 3'd2) begin n_fail++; $display("FAIL b2b_second got=%h/%0d lat=%0d exp=%h/2 lat=17", WData, Rw, lat, ref_mul(a2, b2, 1'b0, 1'b0)); end
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic test_random();
    int lat, we_cnt, stall; logic [15:0] d, a, b, e; logic [2:0] rw, addr; bit s, h, st, dn, bz;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (i % 6 == 0) a = 16'h8000;
      if (i % 6 == 1) b = 16'h0000;
      s = 1'($urandom_range(0, 1)); h = 1'($urandom_range(0, 1));
      addr = 3'($urandom_range(0, 7)); stall = $urandom_range(0, 3);
      run_op(a, b, s, h, addr, stall, 1'b0, lat, d, rw, we_cnt, st, dn, bz);
      e = ref_mul(a, b, s, h);
      n_checks++;
      if (d !== e || rw !== addr || we_cnt != 1 || !st || !dn || lat != 17) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h s=%0d h=%0d got=%h/%0d we=%0d lat=%0d exp=%h/%0d we=1 lat=17",
                 i, a, b, s, h, d, rw, we_cnt, lat, e, addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_unsigned_max();
    test_signed();
    test_grant_stall();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
